// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART blocks (transmitter and receiver).
//   uart_tx_state_e           : transmitter FSM states
//   UART_CLKS_PER_BIT_115200  : clocks per bit for 115200 baud from 50 MHz
//   UART_FRAME_BITS           : bits per 8N1 frame (start + 8 data + stop)
//   UART_DATA_BITS            : data bits per frame
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_CLKS_PER_BIT_115200 = 434;
  localparam int UART_FRAME_BITS          = 10;
  localparam int UART_DATA_BITS           = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock circular-buffer FIFO. Pointers are one bit wider than the
// address so that full and empty can be told apart without a separate flag.
// A push is refused while full, even if a pop happens in the same cycle.
// A pop while empty is ignored.
// Ports:
//   i_clk    : clock
//   i_rst_n  : asynchronous active-low reset (flushes the FIFO)
//   i_push   : write request, i_data is written when not full
//   i_data   : write data
//   i_pop    : read request, head is discarded when not empty
//   o_data   : head of the FIFO (valid when o_empty is low)
//   o_full   : no free entry
//   o_empty  : no stored entry
//   o_count  : occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push_ok;
  logic             w_pop_ok;

  // Same address with differing wrap bits means the writer is a full lap ahead.
  assign o_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                   (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign o_empty = (r_wr_ptr == r_rd_ptr);

  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
  assign o_count = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// UART transmitter (8N1, LSB first) fed by a byte FIFO.
//
// Handshake (valid/ready): a byte is transferred on a rising edge where
// i_valid and o_ready are both high. o_ready depends only on registered FIFO
// state, never on i_valid. i_valid may be held high with no transfer while
// o_ready is low; i_data is ignored in those cycles.
//
// Ports:
//   i_clk        : system clock
//   i_rst_n      : asynchronous active-low reset (abandons frame, flushes FIFO)
//   i_data       : byte to transmit
//   i_valid      : i_data is valid
//   o_ready      : FIFO not full
//   o_txd        : registered serial line, idle high
//   o_busy       : frame in flight or FIFO non-empty
//   o_count      : FIFO occupancy
//   o_dbg_state  : current FSM state (uart_tx_state_e encoding)
// -----------------------------------------------------------------------------
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_115200,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [7:0]                    i_data,
  input  logic                          i_valid,
  output logic                          o_ready,
  output logic                          o_txd,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_count,
  output logic [1:0]                    o_dbg_state
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  uart_tx_state_e r_state;
  uart_tx_state_e w_state_nxt;
  logic [BW-1:0]  r_baud;
  logic [BW-1:0]  w_baud_nxt;
  logic [2:0]     r_bit;
  logic [2:0]     w_bit_nxt;
  logic [7:0]     r_shift;
  logic [7:0]     w_shift_nxt;
  logic           r_txd;
  logic           w_txd_nxt;

  logic           w_pop;
  logic           w_full;
  logic           w_empty;
  logic [7:0]     w_head;
  logic           w_baud_last;

  // ---------------------------------------------------------------------------
  // Byte FIFO: every byte goes through it, there is no bypass path.
  // ---------------------------------------------------------------------------
  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (i_valid),
    .i_data  (i_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (o_count)
  );

  assign w_baud_last = (r_baud == BAUD_LAST);

  // ---------------------------------------------------------------------------
  // FSM state register, baud counter, bit index, shift register, line driver
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_txd   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_txd   <= w_txd_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. The line value is computed from the next state so the
  // registered o_txd changes on the same edge as the state does.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_pop       = 1'b0;

    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = START;
        end
      end

      START: begin
        if (w_baud_last) begin
          w_baud_nxt  = '0;
          w_state_nxt = DATA;
        end else begin
          w_baud_nxt = r_baud + BW'(1);
        end
      end

      DATA: begin
        if (w_baud_last) begin
          w_baud_nxt  = '0;
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_bit == 3'd7) begin
            w_bit_nxt   = '0;
            w_state_nxt = STOP;
          end else begin
            w_bit_nxt = r_bit + 3'd1;
          end
        end else begin
          w_baud_nxt = r_baud + BW'(1);
        end
      end

      STOP: begin
        if (w_baud_last) begin
          w_baud_nxt = '0;
          // Chain straight into the next start bit so queued frames are
          // contiguous on the line.
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_head;
            w_bit_nxt   = '0;
            w_state_nxt = START;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_baud_nxt = r_baud + BW'(1);
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_baud_nxt  = '0;
        w_bit_nxt   = '0;
      end
    endcase

    case (w_state_nxt)
      START:   w_txd_nxt = 1'b0;
      DATA:    w_txd_nxt = w_shift_nxt[0];
      default: w_txd_nxt = 1'b1;
    endcase
  end

  assign o_txd       = r_txd;
  assign o_ready     = ~w_full;
  assign o_busy      = (r_state != IDLE) | ~w_empty;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
// Self-checking bench for uart_tx_fifo with CLKS_PER_BIT=4, FIFO_DEPTH=16.
// Expected line patterns and counts are hand-computed constants; a frame
// decoder checks every transmitted byte against an expected queue.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int CPB       = 4;
  localparam int DEPTH     = 16;
  localparam int CW        = $clog2(DEPTH) + 1;
  localparam int FRAME_CYC = UART_FRAME_BITS * CPB;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    data = 8'h00;
  logic          valid = 1'b0;
  logic          ready;
  logic          txd;
  logic          busy;
  logic [CW-1:0] count;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_data      (data),
    .i_valid     (valid),
    .o_ready     (ready),
    .o_txd       (txd),
    .o_busy      (busy),
    .o_count     (count),
    .o_dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int         n_total = 0;
  int         n_bad   = 0;
  logic [7:0] exp_q[$];
  logic       mon_en  = 1'b0;
  logic [7:0] mon_byte;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Frame decoder: samples mid-bit on negedges, compares against exp_q.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && rst_n && txd == 1'b0) begin
        repeat (2) @(negedge clk);
        chk("mon_start_bit", 32'(txd), 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          mon_byte[i] = txd;
        end
        repeat (CPB) @(negedge clk);
        chk("mon_stop_bit", 32'(txd), 32'd1);
        if (exp_q.size() == 0) begin
          n_total++;
          n_bad++;
          $display("FAIL mon_unexpected_frame: got %0h expected none at t=%0t", mon_byte, $time);
        end else begin
          chk("mon_byte", 32'(mon_byte), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("test done: total=%0d bad=%0d", n_total, n_bad + 1);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Single-frame vector table: byte and its line pattern in time order
  // (bit 0 = start, bits 1..8 = data LSB first, bit 9 = stop).
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;

  vec_t       vecs[6];
  logic [9:0] b2b_f[3];
  logic [7:0] se_b[5];

  initial begin
    vecs[0] = '{data: 8'h55, frame: 10'b1_01010101_0};
    vecs[1] = '{data: 8'hA5, frame: 10'b1_10100101_0};
    vecs[2] = '{data: 8'h00, frame: 10'b1_00000000_0};
    vecs[3] = '{data: 8'hFF, frame: 10'b1_11111111_0};
    vecs[4] = '{data: 8'h0F, frame: 10'b1_00001111_0};
    vecs[5] = '{data: 8'h80, frame: 10'b1_10000000_0};
    b2b_f[0] = 10'b1_10100101_0;
    b2b_f[1] = 10'b1_00000000_0;
    b2b_f[2] = 10'b1_11111111_0;
    se_b[0] = 8'h11; se_b[1] = 8'h22; se_b[2] = 8'h33; se_b[3] = 8'h44; se_b[4] = 8'h5A;

    // ---- Reset values ------------------------------------------------------
    #22;
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_txd", 32'(txd), 32'd1);

    // ---- Table-driven single frames ---------------------------------------
    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      chk("tbl_ready", 32'(ready), 32'd1);
      valid = 1'b1;
      data  = vecs[v].data;
      @(posedge clk);                  // push edge N
      #1;
      valid = 1'b0;
      exp_q.push_back(vecs[v].data);
      @(negedge clk);
      chk("tbl_count_after_push", 32'(count), 32'd1);
      chk("tbl_busy_after_push", 32'(busy), 32'd1);
      chk("tbl_txd_before_pop", 32'(txd), 32'd1);
      for (int k = 0; k < FRAME_CYC; k++) begin
        @(negedge clk);                // cycle after edge N+1+k
        chk("tbl_txd", 32'(txd), 32'(vecs[v].frame[k / CPB]));
        if (k == 0) chk("tbl_count_after_pop", 32'(count), 32'd0);
      end
      chk("tbl_busy_last_stop", 32'(busy), 32'd1);
      @(negedge clk);                  // after edge N+41
      chk("tbl_busy_drop", 32'(busy), 32'd0);
      chk("tbl_txd_idle", 32'(txd), 32'd1);
      repeat (3) @(negedge clk);
    end

    // ---- Back-to-back A5, 00, FF ------------------------------------------
    @(negedge clk);
    valid = 1'b1;
    data  = 8'hA5;
    @(posedge clk); #1;                // edge N
    exp_q.push_back(8'hA5);
    chk("b2b_count_n", 32'(count), 32'd1);
    data = 8'h00;
    @(posedge clk); #1;                // edge N+1: push and pop
    exp_q.push_back(8'h00);
    chk("b2b_count_n1", 32'(count), 32'd1);
    chk("b2b_txd_k0", 32'(txd), 32'd0);
    data = 8'hFF;
    @(posedge clk); #1;                // edge N+2
    exp_q.push_back(8'hFF);
    valid = 1'b0;
    chk("b2b_count_n2", 32'(count), 32'd2);
    for (int k = 1; k < 3 * FRAME_CYC; k++) begin
      @(negedge clk);
      chk("b2b_txd", 32'(txd), 32'(b2b_f[k / FRAME_CYC][(k % FRAME_CYC) / CPB]));
    end
    @(negedge clk);
    chk("b2b_busy_drop", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);

    // ---- Push on the STOP-to-START pop edge with count=3 -------------------
    @(negedge clk);
    valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data = se_b[i];
      @(posedge clk); #1;              // edges N..N+3
      exp_q.push_back(se_b[i]);
    end
    valid = 1'b0;
    chk("se_count_pre", 32'(count), 32'd3);
    repeat (37) @(posedge clk);        // edges N+4..N+40
    #1;
    chk("se_count_stop", 32'(count), 32'd3);
    chk("se_txd_stop", 32'(txd), 32'd1);
    valid = 1'b1;
    data  = se_b[4];
    @(posedge clk); #1;                // edge N+41: pop and push together
    valid = 1'b0;
    exp_q.push_back(se_b[4]);
    chk("se_count_same_edge", 32'(count), 32'd3);
    chk("se_txd_restart", 32'(txd), 32'd0);
    repeat (4 * FRAME_CYC + 5) @(negedge clk);
    chk("se_busy_drop", 32'(busy), 32'd0);
    chk("se_count_drained", 32'(count), 32'd0);
    chk("se_queue_drained", 32'(exp_q.size()), 32'd0);

    // ---- FIFO full with i_valid held from reset, 0xEE while full -----------
    rst_n = 1'b0;
    valid = 1'b1;
    data  = 8'h30;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      @(posedge clk); #1;              // edge E_k
      exp_q.push_back(data);
      chk("full_count", 32'(count), 32'((k == 0) ? 1 : k));
      chk("full_ready", 32'(ready), 32'((k < 16) ? 1 : 0));
      data = (k < 16) ? 8'(8'h31 + k) : 8'hEE;
    end
    for (int k = 17; k <= 40; k++) begin
      @(posedge clk); #1;
      chk("full_hold_ready", 32'(ready), 32'd0);
      chk("full_hold_count", 32'(count), 32'd16);
    end
    @(posedge clk); #1;                // edge E41: next pop
    chk("full_ready_return", 32'(ready), 32'd1);
    chk("full_count_pop", 32'(count), 32'd15);
    valid = 1'b0;
    repeat (16 * FRAME_CYC + 10) @(negedge clk);
    chk("full_busy_drop", 32'(busy), 32'd0);
    chk("full_queue_drained", 32'(exp_q.size()), 32'd0);

    // ---- Reset during DATA bit 3 of 0x0F with two bytes queued -------------
    mon_en = 1'b0;
    @(negedge clk);
    valid = 1'b1;
    data  = 8'h0F;
    @(posedge clk); #1;                // edge N
    data = 8'hAA;
    @(posedge clk); #1;                // edge N+1: pop 0x0F
    data = 8'hBB;
    @(posedge clk); #1;                // edge N+2
    valid = 1'b0;
    chk("rmf_count_queued", 32'(count), 32'd2);
    repeat (17) @(negedge clk);        // negedge after N+18: data bit 3
    chk("rmf_state_data", 32'(dbg_state), 32'(DATA));
    chk("rmf_txd_bit3", 32'(txd), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rmf_txd_reset", 32'(txd), 32'd1);
    chk("rmf_count_reset", 32'(count), 32'd0);
    chk("rmf_busy_reset", 32'(busy), 32'd0);
    chk("rmf_ready_reset", 32'(ready), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      chk("rmf_txd_idle", 32'(txd), 32'd1);
    end
    chk("rmf_busy_idle", 32'(busy), 32'd0);
    chk("rmf_count_idle", 32'(count), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
